// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg -- shared constants and encodings for the modulo-N counters.
//
// Contents:
//   CNT_WIDTH   : default counter register width (bits)
//   CNT_MODULUS : default count range 0..CNT_MODULUS-1
//   dir_e       : count direction encoding on up_dn (DIR_UP = 1, DIR_DN = 0)
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MODULUS = 12;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/modn_next.sv
// ---------------------------------------------------------------------------
// modn_next -- combinational next-value and terminal-detect unit for a
// modulo-MODULUS up/down counter.
//
// Ports:
//   q       in  [WIDTH-1:0] current count value
//   up_dn   in              direction (DIR_UP / DIR_DN from counter_pkg)
//   q_next  out [WIDTH-1:0] value after one step in the selected direction
//   at_term out             q is terminal for the direction (up: MODULUS-1,
//                           down: 0), i.e. the next step wraps
// ---------------------------------------------------------------------------
module modn_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MODULUS
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q_next,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  // Wrap is decided by explicit compare against the terminal value rather
  // than by letting the WIDTH-bit adder overflow, so any modulus is exact.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    at_term = 1'b0;
    q_next  = q;
    if (dir_e'(up_dn) == DIR_UP) begin
      at_term = (q == MAX_VAL);
      q_next  = at_term ? '0 : q + WIDTH'(1);
    end else begin
      at_term = (q == '0);
      q_next  = at_term ? MAX_VAL : q - WIDTH'(1);
    end
  end

endmodule : modn_next

// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter -- cascadable modulo-MODULUS up/down counter with
// synchronous parallel load and rejected-load flag.
//
// Ports:
//   clk      in               rising-edge clock
//   rst      in               asynchronous active-low reset
//   en       in               count enable / cascade carry-in
//   load     in               synchronous parallel load request (beats en)
//   data     in  [WIDTH-1:0]  parallel load value (accepted if < MODULUS)
//   up_dn    in               direction: 1 = up, 0 = down
//   q        out [WIDTH-1:0]  registered count value
//   tc       out              terminal count / carry-out (combinational)
//   load_err out              one-cycle flag after a rejected load
//   wrap_cnt out [WRAP_W-1:0] saturating count of carry-out events
//                             (only when MODN_WRAP_CNT_EN is defined)
//
// Build option: define MODN_WRAP_CNT_EN to add the wrap_cnt port/counter.
// ---------------------------------------------------------------------------
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MODULUS
`ifdef MODN_WRAP_CNT_EN
  ,
  parameter int WRAP_W  = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             load_err
`ifdef MODN_WRAP_CNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  logic [WIDTH-1:0] q_next;
  logic             at_term;
  logic             load_ok;

  modn_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q),
    .up_dn   (up_dn),
    .q_next  (q_next),
    .at_term (at_term)
  );

  // Loads of out-of-range values are refused so q never leaves 0..MODULUS-1.
  assign load_ok = (32'(data) < 32'(MODULUS));

  // Carry-out is gated by reset: while held in reset q=0 would otherwise
  // look terminal to a down-counting stage and ripple into the next one.
  assign tc = rst & en & at_term;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      load_err <= 1'b0;
`ifdef MODN_WRAP_CNT_EN
      wrap_cnt <= '0;
`endif
    end else begin
      load_err <= load & ~load_ok;

      if (load) begin
        if (load_ok) begin
          q <= data;
        end
      end else if (en) begin
        q <= q_next;
      end

`ifdef MODN_WRAP_CNT_EN
      // Counts carry-outs that actually wrap (a load overrides the wrap).
      if (tc && !load && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
`endif
    end
  end

endmodule : modn_updown_counter

// File: tb/tb_modn_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_updown_counter -- self-checking bench for modn_updown_counter.
// A behavioural model (modular arithmetic on integers) predicts q, tc,
// load_err and, with MODN_WRAP_CNT_EN, wrap_cnt. Directed sequences are
// followed by randomized stimulus and a two-stage cascade run.
// ---------------------------------------------------------------------------
module tb_modn_updown_counter;

  localparam int W  = 4;
  localparam int M  = 12;
`ifdef MODN_WRAP_CNT_EN
  localparam int WW = 2;
  localparam int WC_MAX = (1 << WW) - 1;
`endif

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         en    = 1'b0;
  logic         load  = 1'b0;
  logic         up_dn = 1'b1;
  logic [W-1:0] data  = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         load_err;

  logic         cen = 1'b0;
  logic [W-1:0] q0, q1;
  logic         tc0, tc1, le0, le1;

`ifdef MODN_WRAP_CNT_EN
  logic [WW-1:0] wrap_cnt, wc0, wc1;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mq   = 0;
  int merr = 0;
  int mwc  = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(
    .WIDTH   (W),
    .MODULUS (M)
`ifdef MODN_WRAP_CNT_EN
    , .WRAP_W (WW)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .data     (data),
    .up_dn    (up_dn),
    .q        (q),
    .tc       (tc),
    .load_err (load_err)
`ifdef MODN_WRAP_CNT_EN
    , .wrap_cnt (wrap_cnt)
`endif
  );

  modn_updown_counter #(
    .WIDTH   (W),
    .MODULUS (M)
`ifdef MODN_WRAP_CNT_EN
    , .WRAP_W (WW)
`endif
  ) c0 (
    .clk      (clk),
    .rst      (rst),
    .en       (cen),
    .load     (1'b0),
    .data     (4'd0),
    .up_dn    (1'b1),
    .q        (q0),
    .tc       (tc0),
    .load_err (le0)
`ifdef MODN_WRAP_CNT_EN
    , .wrap_cnt (wc0)
`endif
  );

  modn_updown_counter #(
    .WIDTH   (W),
    .MODULUS (M)
`ifdef MODN_WRAP_CNT_EN
    , .WRAP_W (WW)
`endif
  ) c1 (
    .clk      (clk),
    .rst      (rst),
    .en       (tc0),
    .load     (1'b0),
    .data     (4'd0),
    .up_dn    (1'b1),
    .q        (q1),
    .tc       (tc1),
    .load_err (le1)
`ifdef MODN_WRAP_CNT_EN
    , .wrap_cnt (wc1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_tc();
    if (!en) return 0;
    return up_dn ? int'(mq == M - 1) : int'(mq == 0);
  endfunction

  // One clock of stimulus: drive at negedge, check tc combinationally,
  // advance the model across the posedge, then check registered outputs.
  task automatic step(input logic e, input logic l, input logic [W-1:0] d, input logic u);
    int tcx;
    @(negedge clk);
    en = e; load = l; data = d; up_dn = u;
    #1;
    tcx = exp_tc();
    check("tc", 32'(tc), tcx);
    @(posedge clk);
    #1;
    if (l) begin
      merr = (int'(d) >= M) ? 1 : 0;
      if (int'(d) < M) mq = int'(d);
    end else begin
      merr = 0;
      if (e) mq = u ? (mq + 1) % M : (mq + M - 1) % M;
    end
`ifdef MODN_WRAP_CNT_EN
    if (tcx == 1 && !l && mwc < WC_MAX) mwc++;
    check("wrap_cnt", 32'(wrap_cnt), mwc);
`endif
    check("q", 32'(q), mq);
    check("load_err", 32'(load_err), merr);
  endtask

  // Asynchronous reset pulse placed between clock edges; the outputs must
  // clear without waiting for a clock, and tc must stay low even though the
  // inputs (en=1, down) would make q=0 terminal.
  task automatic async_reset();
    @(negedge clk);
    en = 1'b1; load = 1'b0; up_dn = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_load_err", 32'(load_err), 0);
    check("rst_tc", 32'(tc), 0);
    check("rst_casc", 32'({q1, q0}), 0);
    mq = 0; merr = 0; mwc = 0;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; up_dn = 1'b1;
  endtask

  initial begin
    #1;
    check("init_q", 32'(q), 0);
    check("init_load_err", 32'(load_err), 0);
    check("init_tc", 32'(tc), 0);
    @(negedge clk);
    rst = 1'b1;

    // Count up 14 cycles: 1..11, 0, 1, 2 ... tc only while q == 11.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Load 2 then count down 4: 1, 0, 11, 10.
    step(1'b0, 1'b1, 4'b0010, 1'b1);
    check("load2", 32'(q), 2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("down_wrap", 32'(q), 10);

    // Rejected load while q == 5.
    step(1'b0, 1'b1, 4'd5, 1'b0);
    step(1'b1, 1'b1, 4'b1110, 1'b1);
    check("rej_q", 32'(q), 5);
    check("rej_err", 32'(load_err), 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("rej_err_clr", 32'(load_err), 0);

    // Boundary loads: MODULUS rejected, MODULUS-1 accepted.
    step(1'b0, 1'b1, 4'd12, 1'b1);
    step(1'b0, 1'b1, 4'd11, 1'b0);
    check("load11", 32'(q), 11);

    // Load beats en on the same edge.
    step(1'b0, 1'b1, 4'd7, 1'b1);
    step(1'b1, 1'b1, 4'd3, 1'b1);
    check("load_wins", 32'(q), 3);

    async_reset();
    step(1'b1, 1'b0, '0, 1'b1);
    check("resume", 32'(q), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

`ifdef MODN_WRAP_CNT_EN
    // Five full up-wraps: wrap_cnt 1, 2, 3, 3, 3.
    async_reset();
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < M; i++) step(1'b1, 1'b0, '0, 1'b1);
      check("wrap_tbl", 32'(wrap_cnt), (k < WC_MAX) ? k : WC_MAX);
    end
`endif

    // Two-stage cascade: stage 1 steps once per 12 stage-0 counts.
    async_reset();
    @(negedge clk);
    cen = 1'b1;
    for (int n = 1; n <= M * M; n++) begin
      @(posedge clk);
      #1;
      check("casc_q0", 32'(q0), n % M);
      check("casc_q1", 32'(q1), (n / M) % M);
    end
    check("casc_full", 32'({q1, q0}), 0);
    @(negedge clk);
    cen = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_modn_updown_counter

// File: doc/modn_updown_counter.md
MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter register width in bits.
REQ-002 SHALL have parameter MODULUS, default 12, meaning count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  count enable, usable as cascade carry-in.
REQ-006 SHALL have port load  input  1  synchronous parallel load request.
REQ-007 SHALL have port data  input  WIDTH  parallel load value.
REQ-008 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port q  output  WIDTH  registered count value.
REQ-010 SHALL have port tc  output  1  terminal-count / cascade carry-out, combinational.
REQ-011 SHALL have port load_err  output  1  registered one-cycle flag for a rejected load.

Function
REQ-012 SHALL apply per-edge priority: rst, then load, then en, else hold.
REQ-013 SHALL, on load=1 with data < MODULUS, set q=data at the next edge, independent of en and up_dn.
REQ-014 SHALL, on load=1 with data >= MODULUS, leave q unchanged and assert load_err for exactly the following cycle; load_err=0 in all other cycles.
REQ-015 SHALL, on en=1, load=0, up_dn=1, advance q by 1, wrapping MODULUS-1 -> 0.
REQ-016 SHALL, on en=1, load=0, up_dn=0, decrement q by 1, wrapping 0 -> MODULUS-1.
REQ-017 SHALL drive tc=1 iff en=1 and q is terminal for the current up_dn (up: MODULUS-1; down: 0), so tc feeds the next stage's en.
REQ-018 SHALL let an up_dn change take effect on the same edge and update tc combinationally in the same cycle.
REQ-019 SHALL have one-cycle latency from load/en sampling to q update, with no pipeline stages.
REQ-020 SHALL never present q >= MODULUS outside reset.
REQ-021 SHALL perform all arithmetic in WIDTH bits, with wrap handled by explicit compare, not natural overflow, so non-power-of-two moduli are exact.

Reset
REQ-022 SHALL, when rst=0, immediately force q=0, load_err=0 and any optional state to 0, regardless of clk.
REQ-023 SHALL resume counting from 0 on the first rising edge after rst deasserts, including mid-count or mid-load deassertion.
REQ-024 SHALL hold tc=0 during reset, which follows from en being gated by reset state.

Configuration
REQ-025 SHALL support macro MODN_WRAP_CNT_EN; when defined, add output wrap_cnt of width WRAP_W (parameter, default 8).
REQ-026 SHALL, when MODN_WRAP_CNT_EN is defined, increment wrap_cnt on every edge where tc=1 and load=0, saturating at all-ones.
REQ-027 SHALL, when MODN_WRAP_CNT_EN is defined, reset wrap_cnt to 0 and leave it unaffected by load.
REQ-028 SHALL, when MODN_WRAP_CNT_EN is absent, omit wrap_cnt port and logic entirely, with all other behaviour identical.

Structure
REQ-029 SHALL take the direction encodings (DIR_UP, DIR_DN) and the default WIDTH/MODULUS constants from shared package counter_pkg.
REQ-030 SHALL use one sub-module, modn_next, a combinational next-value/terminal-detect unit (q, up_dn -> q_next, at_term), instantiated once.
REQ-031 SHALL contain all state in a single always block in the top module.

Verification
REQ-032 SHALL cover: rst=0 then release, en=1, up_dn=1 for 14 cycles -> q 0..11, 0, 1; tc=1 only while q=11.
REQ-033 SHALL cover: load=1 data=4'b0010, then en=1 up_dn=0 for 4 cycles -> q 2, 1, 0, 11, 10; tc=1 while q=0.
REQ-034 SHALL cover: load=1 data=4'b1110 while q=5 -> q stays 5, load_err=1 for one cycle, then 0.
REQ-035 SHALL cover: load=1 and en=1 same edge with data=3, q=7 -> q=3 (load wins); rst=0 asserted between edges -> q=0 without a clock edge.
REQ-036 SHALL cover: two instances cascaded (stage-1 en = stage-0 tc), up for 144 cycles -> {q1, q0} = {0, 0} again; stage-1 steps exactly once per 12 cycles.
REQ-037 SHALL cover, with MODN_WRAP_CNT_EN and WRAP_W=2: 5 full up-wraps -> wrap_cnt 1, 2, 3, 3, 3 (saturates); without the macro, wrap_cnt port absent and compilation clean.
